// File: rtl/cmp_stream_tracker.sv
// cmp_stream_tracker
// Registered, handshaked magnitude comparator with outcome statistics.
// A single result register sits behind a valid/ready pair. Each accepted
// (A, B) sample produces gr/le/eq one cycle later. The same accept edge
// updates saturating outcome counters and a running min/max of A.
// Signed comparisons flip the operand MSB, which turns two's-complement
// ordering into plain unsigned ordering. The same comparator can then
// serve both modes.

module cmp_stream_tracker #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic             signed_mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gr,
    output logic             le,
    output logic             eq,
    output logic [CNT_W-1:0] gr_cnt,
    output logic [CNT_W-1:0] le_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [N-1:0]     max_a,
    output logic [N-1:0]     min_a,
    output logic             track_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Map a value onto an unsigned ordering key. In signed mode the sign bit
    // is inverted, so the most negative value becomes the smallest key.
    function automatic logic [N-1:0] order_key(input logic [N-1:0] v, input logic s);
        order_key = {v[N-1] ^ s, v[N-2:0]};
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    logic             accept;
    logic [N-1:0]     key_a;
    logic [N-1:0]     key_b;
    logic [N-1:0]     key_max;
    logic [N-1:0]     key_min;
    logic             a_gt_b;
    logic             a_lt_b;

    logic [CNT_W-1:0] gr_cnt_next;
    logic [CNT_W-1:0] le_cnt_next;
    logic [CNT_W-1:0] eq_cnt_next;
    logic [N-1:0]     max_a_next;
    logic [N-1:0]     min_a_next;
    logic             track_base;
    logic             track_next;

    // The result register can take a new sample whenever it is empty or
    // being drained this cycle. This allows full throughput with no bubble.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign key_a   = order_key(A, signed_mode);
    assign key_b   = order_key(B, signed_mode);
    assign key_max = order_key(max_a, signed_mode);
    assign key_min = order_key(min_a, signed_mode);
    assign a_gt_b  = key_a > key_b;
    assign a_lt_b  = key_a < key_b;

    // Next statistics state. A clear is applied first, so an accept in the
    // same cycle builds on the cleared values.
    always_comb begin
        // NOTE: every output of this block is assigned a default up front;
        // a path that skips an assignment would otherwise infer a latch.
        gr_cnt_next = clear ? '0 : gr_cnt;
        le_cnt_next = clear ? '0 : le_cnt;
        eq_cnt_next = clear ? '0 : eq_cnt;
        max_a_next  = clear ? '0 : max_a;
        min_a_next  = clear ? '0 : min_a;
        track_base  = !clear && track_valid;
        track_next  = track_base;

        if (accept) begin
            if (a_gt_b) begin
                gr_cnt_next = sat_inc(gr_cnt_next);
            end else if (a_lt_b) begin
                le_cnt_next = sat_inc(le_cnt_next);
            end else begin
                eq_cnt_next = sat_inc(eq_cnt_next);
            end

            if (!track_base) begin
                max_a_next = A;
                min_a_next = A;
                track_next = 1'b1;
            end else begin
                if (key_a > key_max) max_a_next = A;
                if (key_a < key_min) min_a_next = A;
            end
        end
    end

    // Result register: load on accept, empty on drain, and hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments, so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            out_valid <= 1'b0;
            gr        <= 1'b0;
            le        <= 1'b0;
            eq        <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            gr        <= a_gt_b;
            le        <= a_lt_b;
            eq        <= !a_gt_b && !a_lt_b;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Statistics registers: counters, min/max and track_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gr_cnt      <= '0;
            le_cnt      <= '0;
            eq_cnt      <= '0;
            max_a       <= '0;
            min_a       <= '0;
            track_valid <= 1'b0;
        end else begin
            gr_cnt      <= gr_cnt_next;
            le_cnt      <= le_cnt_next;
            eq_cnt      <= eq_cnt_next;
            max_a       <= max_a_next;
            min_a       <= min_a_next;
            track_valid <= track_next;
        end
    end

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Self-checking bench for cmp_stream_tracker.
// Two instances share all inputs: one uses 16-bit counters and the other
// uses 2-bit counters to exercise saturation. Expected results are pushed
// to a queue on accept and popped when the held result is consumed.

module tb_cmp_stream_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       signed_mode;
    logic       clear;
    logic       out_ready;

    logic        in_ready, out_valid, gr, le, eq, track_valid;
    logic [15:0] gr_cnt, le_cnt, eq_cnt;
    logic [7:0]  max_a, min_a;

    logic        in_ready_s, out_valid_s, gr_s, le_s, eq_s, track_valid_s;
    logic [1:0]  gr_cnt_s, le_cnt_s, eq_cnt_s;
    logic [7:0]  max_a_s, min_a_s;

    always #5 clk = ~clk;

    cmp_stream_tracker #(.N(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .signed_mode(signed_mode), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .gr(gr), .le(le), .eq(eq),
        .gr_cnt(gr_cnt), .le_cnt(le_cnt), .eq_cnt(eq_cnt),
        .max_a(max_a), .min_a(min_a), .track_valid(track_valid)
    );

    cmp_stream_tracker #(.N(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .A(a), .B(b), .signed_mode(signed_mode), .clear(clear),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .gr(gr_s), .le(le_s), .eq(eq_s),
        .gr_cnt(gr_cnt_s), .le_cnt(le_cnt_s), .eq_cnt(eq_cnt_s),
        .max_a(max_a_s), .min_a(min_a_s), .track_valid(track_valid_s)
    );

    // Scoreboard and reference model state.
    logic [2:0] q[$];          // expected {gr, le, eq} for results not yet consumed
    int         m_cnt[3];      // 16-bit model counters: 0 gr, 1 le, 2 eq
    int         m_sat[3];      // 2-bit model counters
    logic [7:0] m_max, m_min;
    logic       m_trk;
    int         n_acc;
    int         passed = 0;
    int         total  = 0;

    function automatic int val(input logic [7:0] v, input logic s);
        if (s) return int'($signed(v));
        return int'(v);
    endfunction

    function automatic void model_clear_stats();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_sat[i] = 0;
        end
        m_max = 8'h00;
        m_min = 8'h00;
        m_trk = 1'b0;
    endfunction

    task automatic drive(input logic [7:0] da, input logic [7:0] db, input logic ds,
                         input logic dv, input logic dr, input logic dc);
        a           = da;
        b           = db;
        signed_mode = ds;
        in_valid    = dv;
        out_ready   = dr;
        clear       = dc;
    endtask

    // Compare every DUT output against the model at a quiet point after an edge.
    task automatic compare_outputs();
        total++;
        if (out_valid !== (q.size() != 0)) $display("FAIL out_valid got %b exp %b", out_valid, q.size() != 0);
        else passed++;
        total++;
        if (out_valid_s !== (q.size() != 0)) $display("FAIL out_valid_sat got %b exp %b", out_valid_s, q.size() != 0);
        else passed++;
        if (q.size() != 0) begin
            total++;
            if ({gr, le, eq} !== q[0]) $display("FAIL flags got %b exp %b", {gr, le, eq}, q[0]);
            else passed++;
        end
        total++;
        if ({gr_cnt, le_cnt, eq_cnt} !== {m_cnt[0][15:0], m_cnt[1][15:0], m_cnt[2][15:0]})
            $display("FAIL counters got %0d/%0d/%0d exp %0d/%0d/%0d",
                     gr_cnt, le_cnt, eq_cnt, m_cnt[0], m_cnt[1], m_cnt[2]);
        else passed++;
        total++;
        if ({gr_cnt_s, le_cnt_s, eq_cnt_s} !== {m_sat[0][1:0], m_sat[1][1:0], m_sat[2][1:0]})
            $display("FAIL sat_counters got %0d/%0d/%0d exp %0d/%0d/%0d",
                     gr_cnt_s, le_cnt_s, eq_cnt_s, m_sat[0], m_sat[1], m_sat[2]);
        else passed++;
        total++;
        if ({track_valid, max_a, min_a} !== {m_trk, m_max, m_min})
            $display("FAIL minmax got trk=%b max=%h min=%h exp trk=%b max=%h min=%h",
                     track_valid, max_a, min_a, m_trk, m_max, m_min);
        else passed++;
    endtask

    // One clock of scoreboard activity with the currently driven inputs.
    task automatic cycle();
        logic exp_ready, consumed, accepted;
        int   o;
        int   va, vb;
        #1;
        exp_ready = (q.size() == 0) || out_ready;
        total++;
        if (in_ready !== exp_ready) $display("FAIL in_ready got %b exp %b", in_ready, exp_ready);
        else passed++;
        consumed = (q.size() != 0) && out_ready;
        accepted = in_valid && exp_ready;
        @(posedge clk);
        #1;
        if (consumed) void'(q.pop_front());
        if (clear) model_clear_stats();
        if (accepted) begin
            va = val(a, signed_mode);
            vb = val(b, signed_mode);
            o  = (va > vb) ? 0 : (va < vb) ? 1 : 2;
            q.push_back(o == 0 ? 3'b100 : o == 1 ? 3'b010 : 3'b001);
            if (m_cnt[o] < 65535) m_cnt[o]++;
            if (m_sat[o] < 3) m_sat[o]++;
            if (!m_trk) begin
                m_max = a;
                m_min = a;
                m_trk = 1'b1;
            end else begin
                if (va > val(m_max, signed_mode)) m_max = a;
                if (va < val(m_min, signed_mode)) m_min = a;
            end
            n_acc++;
        end
        compare_outputs();
    endtask

    task automatic test_reset();
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        q.delete();
        model_clear_stats();
        #23;
        total++;
        if ({out_valid, gr, le, eq, gr_cnt, le_cnt, eq_cnt, max_a, min_a, track_valid} !== '0)
            $display("FAIL reset_state got nonzero outputs ov=%b cnt=%0d/%0d/%0d trk=%b",
                     out_valid, gr_cnt, le_cnt, eq_cnt, track_valid);
        else passed++;
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
        else passed++;
        cycle();
    endtask

    task automatic test_compare();
        drive(8'h80, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0); cycle();   // unsigned: gr
        drive(8'h80, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0); cycle();   // signed: le
        drive(8'h05, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0); cycle();   // eq
        drive(8'hFF, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0); cycle();   // -1 < 1
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); cycle();   // drain
        cycle();
    endtask

    task automatic test_back_to_back();
        drive(8'h09, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0); cycle();   // first accept, consumer stalled
        drive(8'h03, 8'h09, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle();                    // held stable, in_ready low
        drive(8'h03, 8'h09, 1'b0, 1'b1, 1'b1, 1'b0); cycle();   // swap in second result
        total++;
        if ({out_valid, le} !== 2'b11) $display("FAIL back_to_back got ov=%b le=%b exp 1 1", out_valid, le);
        else passed++;
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    endtask

    task automatic test_saturation();
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1); cycle();   // clear alone
        for (int i = 0; i < 5; i++) begin
            drive(8'h09, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        total++;
        if (gr_cnt_s !== 2'd3) $display("FAIL saturate got %0d exp 3", gr_cnt_s);
        else passed++;
        drive(8'h01, 8'h09, 1'b0, 1'b1, 1'b1, 1'b1); cycle();   // clear + accept
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
    endtask

    task automatic test_minmax();
        logic [7:0] seq[4];
        seq = '{8'd20, 8'd5, 8'd200, 8'd7};
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
        for (int i = 0; i < 4; i++) begin
            drive(seq[i], 8'd50, 1'b0, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        drive(8'd9, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0); cycle();     // leave a result held
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        model_clear_stats();
        total++;
        if ({out_valid, out_valid_s, gr_cnt, le_cnt, eq_cnt, max_a, min_a, track_valid} !== '0)
            $display("FAIL async_reset got ov=%b cnt=%0d/%0d/%0d max=%h min=%h trk=%b",
                     out_valid, gr_cnt, le_cnt, eq_cnt, max_a, min_a, track_valid);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        int target;
        target = n_acc + 1000;
        for (int c = 0; c < 20000 && n_acc < target; c++) begin
            drive(8'($urandom), 8'($urandom_range(0, 3) == 0 ? a : 8'($urandom)),
                  1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 49) == 0));
            cycle();
        end
        total++;
        if (n_acc < target) $display("FAIL random_budget got %0d accepts exp %0d", n_acc, target);
        else passed++;
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        total++;
        if (q.size() != 0 || out_valid !== 1'b0) $display("FAIL drain got ov=%b pending=%0d exp 0 0", out_valid, q.size());
        else passed++;
    endtask

    initial begin
        n_acc = 0;
        test_reset();
        test_compare();
        test_back_to_back();
        test_saturation();
        test_minmax();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cmp_stream_tracker.md
Name: cmp_stream_tracker

Overview:
- Streaming, registered successor to the team's combinational N-bit magnitude comparator.
- Accepts (A, B) pairs over a valid/ready handshake and returns registered gr/le/eq flags.
- Supports unsigned or two's-complement signed comparison.
- Keeps saturating counters of each outcome and a running min/max of A since the last clear; used as a statistics front-end beside the 8-bit ALU.

Parameters:
- N, 8, operand width in bits (N >= 2).
- CNT_W, 16, width of each outcome counter (CNT_W >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B/signed_mode valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- A  input  N  operand A.
- B  input  N  operand B.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with A/B.
- clear  input  1  synchronous clear of counters and min/max tracking.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer accepts the result.
- gr  output  1  A > B for the held result.
- le  output  1  A < B for the held result.
- eq  output  1  A == B for the held result.
- gr_cnt  output  CNT_W  count of accepted samples with A > B.
- le_cnt  output  CNT_W  count of accepted samples with A < B.
- eq_cnt  output  CNT_W  count of accepted samples with A == B.
- max_a  output  N  largest accepted A since clear, under that sample's mode.
- min_a  output  N  smallest accepted A since clear, under that sample's mode.
- track_valid  output  1  at least one sample accepted since reset or clear.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and internal registers go to 0 (out_valid, gr, le, eq, counters, max_a, min_a, track_valid). After reset, in_ready = 1.
- in_ready = !out_valid || out_ready. This is combinational and forms a single-entry pipeline register with no bubble under continuous flow.
- Accept: in_valid && in_ready at a rising edge.
  - On the next edge: out_valid = 1 and gr/le/eq are loaded.
  - Exactly one of gr/le/eq is 1 whenever out_valid = 1.
  - Latency is 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready with no accept in the same cycle → out_valid = 0 on the next edge. gr/le/eq hold their last values; only out_valid qualifies them.
- Stall: out_valid && !out_ready → in_ready = 0, and gr/le/eq/out_valid hold stable.
- Compare: signed_mode = 1 treats A and B as two's complement; 0 treats them as unsigned. The mode is per-sample; no clear is needed when switching.
- Counters: on accept, the counter matching the outcome increments by 1 and saturates at 2^CNT_W-1 (no wrap). Counters update on the accept edge, with the same timing as the result register.
- Min/max on accept:
  - If track_valid = 0: max_a = min_a = A and track_valid = 1.
  - Otherwise: max_a = A if A > max_a, and min_a = A if A < min_a. These comparisons use the accepted sample's signed_mode.
- clear (synchronous, active-high):
  - Zeroes the three counters, max_a, min_a and track_valid.
  - Does not affect out_valid, gr/le/eq or the handshake.
- clear together with an accept in the same cycle: the clear applies first, then the sample. Counters read 1 in the matching counter and 0 in the others; max_a = min_a = A; track_valid = 1.
- rst_n asserted mid-stream: any held result is discarded (out_valid = 0). No partial counter update.
- Inputs are ignored while in_valid = 0.

Test Plan:
- Reset, then unsigned A=8'h80, B=8'h7F, out_ready=1 → one cycle later out_valid=1, gr=1, le=0, eq=0; gr_cnt=1; max_a=min_a=8'h80; track_valid=1.
- Same pair with signed_mode=1 (-128 vs 127) → le=1, le_cnt=1. Then A=B=8'h05 → eq=1, eq_cnt=1.
- Backpressure: out_ready=0 after the first accept, in_valid held with A=3, B=9 → in_ready=0, and the first result stays stable for 5 cycles. Raise out_ready → the second result le=1 follows on the next cycle with no extra bubble.
- Saturation with CNT_W=2: 5 accepts of A=9, B=1 → gr_cnt sticks at 3. Then clear together with an accept of A=1, B=9 → le_cnt=1, gr_cnt=0, max_a=min_a=1.
- Min/max unsigned sequence A = 20, 5, 200, 7 → min_a=5, max_a=200. Assert rst_n low mid-stream (asynchronous, off-edge) → all outputs 0 immediately.
- Random mixed signed/unsigned stream of 1000 samples with random out_ready → scoreboard matches the flags, counters and min/max; no sample is lost or duplicated.
